// File: rtl/imaging_mode_sequencer_if.sv
// imaging_mode_sequencer_if: watchdog, load and camera-setting signals of the imaging mode sequencer
interface imaging_mode_sequencer_if #(
  parameter int NUM_CAMS  = 2,
  parameter int NUM_MODES = 4,
  parameter int EXP_W     = 2
);
  localparam int MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
  logic                wms;
  logic                capture_busy;
  logic                mode_load_en;
  logic [MODE_W-1:0]   mode_load_val;
  logic [MODE_W-1:0]   mode_idx;
  logic                reduce_resolution;
  logic [NUM_CAMS-1:0] cam_sel_bitmask;
  logic [EXP_W-1:0]    exposure_level;
  logic                mode_changed;
  logic                load_err;
  modport master (
    output wms, capture_busy, mode_load_en, mode_load_val,
    input  mode_idx, reduce_resolution, cam_sel_bitmask, exposure_level, mode_changed, load_err
  );
  modport slave (
    input  wms, capture_busy, mode_load_en, mode_load_val,
    output mode_idx, reduce_resolution, cam_sel_bitmask, exposure_level, mode_changed, load_err
  );
endinterface

// File: rtl/imaging_mode_sequencer.sv
// imaging_mode_sequencer: debounced wms advance / direct load of the imaging mode, deferred while a capture is busy
module imaging_mode_sequencer #(
  parameter int NUM_CAMS        = 2,
  parameter int NUM_MODES       = 4,
  parameter int EXP_W           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter logic [NUM_MODES*(1+NUM_CAMS+EXP_W)-1:0] MODE_TABLE = 20'b11000_00101_11110_01111
) (
  input logic clk,
  input logic reset_n,
  imaging_mode_sequencer_if.slave bus
);
  localparam int EW     = 1 + NUM_CAMS + EXP_W;
  localparam int MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
  localparam int CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  typedef enum logic [1:0] {P_NONE, P_ADV, P_LOAD} pend_t;
  logic              s0, s1, wms_db, tog, adv, ld_ok, chg, err;
  logic [CW-1:0]     cnt;
  pend_t             pend, eff;
  logic [MODE_W-1:0] pend_val, eff_val, cur, nxt;
  // Request merge: an accepted load beats everything, an advance never displaces a pending load
  always_comb begin
    tog     = (s1 != wms_db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    adv     = tog && !wms_db;
    ld_ok   = bus.mode_load_en && (int'(bus.mode_load_val) < NUM_MODES);
    eff     = ld_ok ? P_LOAD : (adv && pend != P_LOAD) ? P_ADV : pend;
    eff_val = ld_ok ? bus.mode_load_val : pend_val;
    nxt     = (eff == P_LOAD) ? eff_val :
              (eff == P_ADV)  ? ((cur == MODE_W'(NUM_MODES - 1)) ? '0 : cur + MODE_W'(1)) : cur;
  end
  // Synchroniser, debouncer, pending request and internal mode state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0       <= 1'b0;
      s1       <= 1'b0;
      wms_db   <= 1'b0;
      cnt      <= '0;
      pend     <= P_NONE;
      pend_val <= '0;
      cur      <= '0;
      chg      <= 1'b0;
      err      <= 1'b0;
    end else begin
      s0       <= bus.wms;
      s1       <= s0;
      wms_db   <= wms_db ^ tog;
      cnt      <= (s1 == wms_db || tog) ? '0 : cnt + CW'(1);
      pend     <= bus.capture_busy ? eff : P_NONE;
      pend_val <= eff_val;
      cur      <= bus.capture_busy ? cur : nxt;
      chg      <= !bus.capture_busy && eff != P_NONE;
      err      <= bus.mode_load_en && !ld_ok;
    end
  end
  // Output stage: every visible signal moves together one edge after the mode state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mode_idx <= '0;
      {bus.reduce_resolution, bus.cam_sel_bitmask, bus.exposure_level} <= MODE_TABLE[EW-1:0];
      bus.mode_changed <= 1'b0;
      bus.load_err     <= 1'b0;
    end else begin
      bus.mode_idx <= cur;
      {bus.reduce_resolution, bus.cam_sel_bitmask, bus.exposure_level} <= MODE_TABLE[int'(cur)*EW +: EW];
      bus.mode_changed <= chg;
      bus.load_err     <= err;
    end
  end
endmodule

// File: tb/tb_imaging_mode_sequencer.sv
// tb_imaging_mode_sequencer: directed checks of debounce, advance, load, deferral and reset behaviour
module tb_imaging_mode_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int chg_cnt = 0;
  int err2_cnt = 0;
  int base;
  imaging_mode_sequencer_if b ();
  imaging_mode_sequencer_if #(.NUM_MODES(5)) b2 ();
  imaging_mode_sequencer #(.DEBOUNCE_CYCLES(4)) dut (.clk(clk), .reset_n(reset_n), .bus(b));
  imaging_mode_sequencer #(
    .NUM_MODES(5), .DEBOUNCE_CYCLES(4),
    .MODE_TABLE(25'b10110_11000_00101_11110_01111)
  ) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  always #5 clk = ~clk;
  // Pulse counters for the no-extra-change checks
  always @(negedge clk) begin
    if (b.mode_changed) chg_cnt++;
    if (b2.load_err) err2_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_mode(input string tag, input int idx, input int rr, input int cam, input int ex);
    check({tag, "_idx"}, 32'(b.mode_idx), idx);
    check({tag, "_rr"}, 32'(b.reduce_resolution), rr);
    check({tag, "_cam"}, 32'(b.cam_sel_bitmask), cam);
    check({tag, "_exp"}, 32'(b.exposure_level), ex);
  endtask
  task automatic pulse();
    b.wms = 1'b1;
    tick(8);
    b.wms = 1'b0;
    tick(8);
  endtask
  initial begin
    b.wms = 0; b.capture_busy = 0; b.mode_load_en = 0; b.mode_load_val = '0;
    b2.wms = 0; b2.capture_busy = 0; b2.mode_load_en = 0; b2.mode_load_val = '0;
    tick(3);
    check_mode("rst", 0, 0, 3, 3);
    check("rst_chg", 32'(b.mode_changed), 0);
    check("rst_err", 32'(b.load_err), 0);
    reset_n = 1'b1;
    base = chg_cnt;
    tick(100);
    check_mode("idle", 0, 0, 3, 3);
    check("idle_pulses", chg_cnt - base, 0);
    // short glitch then a held level with exact latency
    b.wms = 1'b1;
    tick(3);
    b.wms = 1'b0;
    tick(10);
    check("glitch_idx", 32'(b.mode_idx), 0);
    check("glitch_pulses", chg_cnt - base, 0);
    b.wms = 1'b1;
    tick(6);
    check("edge6_idx", 32'(b.mode_idx), 0);
    check("edge6_chg", 32'(b.mode_changed), 0);
    tick(1);
    check_mode("edge7", 1, 1, 3, 2);
    check("edge7_chg", 32'(b.mode_changed), 1);
    tick(1);
    check("edge8_chg", 32'(b.mode_changed), 0);
    tick(4);
    b.wms = 1'b0;
    tick(10);
    check("held_idx", 32'(b.mode_idx), 1);
    check("held_pulses", chg_cnt - base, 1);
    // four clean pulses from mode 0 with wrap
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    base = chg_cnt;
    pulse();
    check("p1_idx", 32'(b.mode_idx), 1);
    pulse();
    check_mode("p2", 2, 0, 1, 1);
    pulse();
    check_mode("p3", 3, 1, 2, 0);
    pulse();
    check_mode("p4", 0, 0, 3, 3);
    check("p4_pulses", chg_cnt - base, 4);
    // deferred: advances, then a load, then an advance that must not displace the load
    b.capture_busy = 1'b1;
    pulse();
    pulse();
    b.mode_load_en = 1'b1; b.mode_load_val = 2'd3;
    tick(1);
    b.mode_load_en = 1'b0;
    pulse();
    check("busy_idx", 32'(b.mode_idx), 0);
    base = chg_cnt;
    b.capture_busy = 1'b0;
    tick(1);
    check("release_e0_idx", 32'(b.mode_idx), 0);
    tick(1);
    check_mode("release", 3, 1, 2, 0);
    check("release_chg", 32'(b.mode_changed), 1);
    tick(20);
    check("release_pulses", chg_cnt - base, 1);
    // advances coalesce while busy; single wrap from 3 to 0
    b.capture_busy = 1'b1;
    pulse();
    pulse();
    base = chg_cnt;
    b.capture_busy = 1'b0;
    tick(20);
    check("coal_idx", 32'(b.mode_idx), 0);
    check("coal_pulses", chg_cnt - base, 1);
    // load 2 in the same cycle as an advance from mode 0
    base = chg_cnt;
    b.wms = 1'b1;
    tick(5);
    b.mode_load_en = 1'b1; b.mode_load_val = 2'd2;
    tick(1);
    b.mode_load_en = 1'b0;
    tick(1);
    check("same_idx", 32'(b.mode_idx), 2);
    check("same_chg", 32'(b.mode_changed), 1);
    tick(3);
    b.wms = 1'b0;
    tick(10);
    check("same_hold_idx", 32'(b.mode_idx), 2);
    check("same_pulses", chg_cnt - base, 1);
    // out-of-range loads on the five-mode instance
    b2.mode_load_en = 1'b1; b2.mode_load_val = 3'd5;
    tick(1);
    b2.mode_load_en = 1'b0;
    check("err_n_lerr", 32'(b2.load_err), 0);
    tick(1);
    check("err_n1_lerr", 32'(b2.load_err), 1);
    check("err_idx", 32'(b2.mode_idx), 0);
    check("err_chg", 32'(b2.mode_changed), 0);
    tick(1);
    check("err_n2_lerr", 32'(b2.load_err), 0);
    b2.mode_load_en = 1'b1; b2.mode_load_val = 3'd4;
    tick(1);
    b2.mode_load_en = 1'b0;
    tick(1);
    check("ld4_idx", 32'(b2.mode_idx), 4);
    check("ld4_rr", 32'(b2.reduce_resolution), 1);
    check("ld4_cam", 32'(b2.cam_sel_bitmask), 1);
    check("ld4_exp", 32'(b2.exposure_level), 2);
    check("ld4_chg", 32'(b2.mode_changed), 1);
    b2.capture_busy = 1'b1;
    b2.mode_load_en = 1'b1; b2.mode_load_val = 3'd2;
    tick(1);
    b2.mode_load_val = 3'd7;
    tick(1);
    b2.mode_load_en = 1'b0;
    tick(3);
    check("pend_idx", 32'(b2.mode_idx), 4);
    b2.capture_busy = 1'b0;
    tick(2);
    check("pend_ld_idx", 32'(b2.mode_idx), 2);
    check("pend_ld_cam", 32'(b2.cam_sel_bitmask), 1);
    check("err_total", err2_cnt, 2);
    // reset discards a pending advance
    b.capture_busy = 1'b1;
    pulse();
    check("rp_busy_idx", 32'(b.mode_idx), 2);
    reset_n = 1'b0;
    #1;
    check("rp_async_idx", 32'(b.mode_idx), 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    base = chg_cnt;
    b.capture_busy = 1'b0;
    tick(10);
    check_mode("rp", 0, 0, 3, 3);
    check("rp_pulses", chg_cnt - base, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
